rx_packet_collector: RTL and testbench
======================================

# rx_packet_collector

Receive-side collector for the CAN multi-node environment. It sits between the receive ports of all CAN nodes (data_out_req, Rx_packet, Rx_ID) and the single HVL-bound output pipe. It captures each accepted frame from any node into a per-node holding slot and arbitrates the slots round-robin into a show-ahead FIFO. The FIFO drains one frame per handshake, so simultaneous receptions on several nodes are serialised without loss.

## Interface
- NODES, 4: number of CAN nodes; must be ≥ 2.
- DATA_SIZE, 64: payload width in bits.
- ID_SIZE, 11: identifier width in bits.
- DEPTH, 8: FIFO entries; must be ≥ 2.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- data_out_req  in  NODES  per-node "frame received" request; may be held high for several cycles.
- rx_packet  in  NODES*DATA_SIZE  node i payload at bits [i*DATA_SIZE +: DATA_SIZE].
- rx_id  in  NODES*ID_SIZE  node i identifier at bits [i*ID_SIZE +: ID_SIZE].
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_packet  out  DATA_SIZE  head payload.
- out_id  out  ID_SIZE  head identifier.
- out_node  out  clog2(NODES)  index of the source node.
- fifo_level  out  clog2(DEPTH+1)  current FIFO occupancy.
- drop_count  out  16  frames dropped since reset; saturates at 16'hFFFF.

## Operation
- **Edge detect.** The block keeps req_q, which holds data_out_req from the previous edge.
  - Capture for node i occurs only on a rise: data_out_req[i]=1 and req_q[i]=0.
  - A held-high request captures once.
  - After reset, req_q=0, so a request that is already high is captured at the first edge with reset low.
- **Holding slot.** Each node has one slot: pend[i], pkt[i], id[i].
  - On capture with pend[i]=0, the slot loads rx_packet/rx_id slice i and sets pend[i]=1.
  - On capture with pend[i]=1 and node i not granted this cycle, the new frame is discarded, the old frame is kept, and drop_count increments by 1 (saturating).
  - On capture in the same cycle node i is granted, the old frame goes to the FIFO, the new frame loads the slot, pend stays 1, and nothing is dropped.
- **Arbiter.** rr_ptr has range 0..NODES-1.
  - Each cycle with can_push true, grant the first pend[j]=1 searching j = rr_ptr, rr_ptr+1, … modulo NODES.
  - On a grant: push {pkt[j], id[j], j}, clear pend[j] (unless recaptured as above), and set rr_ptr = (j+1) mod NODES.
  - With no grant, rr_ptr holds.
  - At most one push per cycle.
  - The arbiter uses registered pend only, so a frame captured at edge k is first grantable at edge k+1.
- **Push condition.** can_push = (fifo_level < DEPTH) || pop.
  - pop = out_valid && out_ready.
- **FIFO.** Show-ahead FIFO with circular read/write pointers that wrap at DEPTH.
  - out_valid = (fifo_level != 0).
  - out_packet, out_id and out_node present the head combinationally from storage.
  - Outputs are don't-care while out_valid=0.
- **Level update.**
  - Push only: fifo_level +1.
  - Pop only: −1.
  - Both: unchanged.
  - Pop while empty is ignored (out_ready=1 while out_valid=0 has no effect).
- **Full behaviour.** With the FIFO full and no pop, there is no grant; pending slots hold their frames and no drop occurs. Drops arise only from slot overwrite.

## Timing
- **Reset values:** out_valid=0, fifo_level=0, drop_count=0, rr_ptr=0, pend=0, req_q=0, FIFO pointers=0. out_packet, out_id and out_node read 0 after reset.
- **Reset mid-operation:** at the reset edge, all pending frames and FIFO contents are discarded; drop_count clears; no output handshake completes.
- **Latency:** a rise sampled at edge k gives pend=1 after k and a FIFO push at k+1, so out_valid=1 after edge k+1 (two edges) when the FIFO is empty and the node wins arbitration.
- **Throughput:** one frame in and one frame out per cycle sustained.
- **Simultaneous rises on all NODES nodes:** frames are pushed on consecutive cycles in round-robin order starting at rr_ptr.

## Test plan
- **Single frame.** Reset, then pulse data_out_req[2] for one cycle with rx_packet slice 2 = 64'hDEAD_BEEF_0000_0001 and rx_id slice 2 = 11'h123, out_ready=1.
  - Expect out_valid two edges later with that payload/id and out_node=2.
  - Expect exactly one pop and fifo_level back to 0.
- **Simultaneous frames.** All 4 nodes rise together with out_ready=1 and rr_ptr=0.
  - Expect out_node sequence 0,1,2,3 on consecutive cycles and drop_count=0.
  - Repeat after a grant leaves rr_ptr=2; expect 2,3,0,1.
- **Held request.** data_out_req[1] held high for 10 cycles.
  - Expect exactly one frame out.
- **Full FIFO and overwrite.** out_ready=0, DEPTH=8, 12 successive single-node frames round-robin across nodes.
  - Expect fifo_level=8, all 4 slots pending, drop_count=0.
  - Then one more rise on node 0: expect drop_count=1.
  - Then out_ready=1: expect 12 frames out in capture order per node, each with its original payload.
- **Full with simultaneous pop and push.** FIFO full, pend[3]=1, out_ready=1 for one cycle.
  - Expect fifo_level to stay at 8 and node 3's frame to enter the FIFO that cycle.
- **Reset mid-operation.** fifo_level=5, two pending slots, drop_count=3; assert reset for one edge.
  - Expect all outputs at reset values.
  - Expect no stale frame to appear afterwards.

Source files
------------

// File: rtl/rx_packet_collector.sv
// Receive-side frame collector: per-node holding slots, round-robin
// arbitration and a show-ahead FIFO towards a single output pipe.
module rx_packet_collector #(
    parameter  int NODES     = 4,
    parameter  int DATA_SIZE = 64,
    parameter  int ID_SIZE   = 11,
    parameter  int DEPTH     = 8,
    localparam int NW        = $clog2(NODES),
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NODES-1:0]             data_out_req,
    input  logic [NODES*DATA_SIZE-1:0]   rx_packet,
    input  logic [NODES*ID_SIZE-1:0]     rx_id,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_SIZE-1:0]         out_packet,
    output logic [ID_SIZE-1:0]           out_id,
    output logic [NW-1:0]                out_node,
    output logic [LW-1:0]                fifo_level,
    output logic [15:0]                  drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = DATA_SIZE + ID_SIZE + NW;

    logic [NODES-1:0]     req_q;
    logic [NODES-1:0]     rise;
    logic [NODES-1:0]     pend_q, pend_d;
    logic [DATA_SIZE-1:0] pkt_q [NODES];
    logic [DATA_SIZE-1:0] pkt_d [NODES];
    logic [ID_SIZE-1:0]   id_q  [NODES];
    logic [ID_SIZE-1:0]   id_d  [NODES];
    logic [NW-1:0]        rr_q, rr_d;
    logic                 gnt;
    logic [NW-1:0]        gnt_idx;
    logic [NW:0]          arb_sum;
    logic [EW-1:0]        mem_q [DEPTH];
    logic [EW-1:0]        head;
    logic [PW-1:0]        wr_q, wr_d;
    logic [PW-1:0]        rd_q, rd_d;
    logic [LW-1:0]        lvl_q, lvl_d;
    logic [15:0]          drop_q, drop_d;
    logic [16:0]          drop_sum;
    logic [NW:0]          ndrop;
    logic                 pop;
    logic                 can_push;

    assign rise     = data_out_req & ~req_q;
    assign pop      = (lvl_q != '0) && out_ready;
    assign can_push = (lvl_q < LW'(DEPTH)) || pop;

    // Round-robin search over registered pend, starting at rr_q
    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        arb_sum = '0;
        for (int k = 0; k < NODES; k++) begin
            arb_sum = {1'b0, rr_q} + (NW+1)'(k);
            if (arb_sum >= (NW+1)'(NODES))
                arb_sum = arb_sum - (NW+1)'(NODES);
            if (can_push && !gnt && pend_q[arb_sum[NW-1:0]]) begin
                gnt     = 1'b1;
                gnt_idx = arb_sum[NW-1:0];
            end
        end
    end

    // Slot capture, release on grant, and overwrite-drop counting
    always_comb begin
        pend_d = pend_q;
        pkt_d  = pkt_q;
        id_d   = id_q;
        ndrop  = '0;
        for (int i = 0; i < NODES; i++) begin
            if (rise[i]) begin
                if (!pend_q[i] || (gnt && gnt_idx == NW'(i))) begin
                    pend_d[i] = 1'b1;
                    pkt_d[i]  = rx_packet[i*DATA_SIZE +: DATA_SIZE];
                    id_d[i]   = rx_id[i*ID_SIZE +: ID_SIZE];
                end else begin
                    ndrop = ndrop + (NW+1)'(1);
                end
            end else if (gnt && gnt_idx == NW'(i)) begin
                pend_d[i] = 1'b0;
            end
        end
        drop_sum = {1'b0, drop_q} + 17'(ndrop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Pointer, occupancy and round-robin pointer next state
    always_comb begin
        rr_d  = rr_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (gnt) begin
            rr_d = (gnt_idx == NW'(NODES-1)) ? '0 : gnt_idx + NW'(1);
            wr_d = (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + PW'(1);
        end
        if (pop)
            rd_d = (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + PW'(1);
        case ({gnt, pop})
            2'b10:   lvl_d = lvl_q + LW'(1);
            2'b01:   lvl_d = lvl_q - LW'(1);
            default: lvl_d = lvl_q;
        endcase
    end

    // Control state with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            req_q  <= '0;
            pend_q <= '0;
            rr_q   <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            lvl_q  <= '0;
            drop_q <= '0;
        end else begin
            req_q  <= data_out_req;
            pend_q <= pend_d;
            rr_q   <= rr_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            lvl_q  <= lvl_d;
            drop_q <= drop_d;
        end
    end

    // Payload storage; validity is tracked by pend_q and lvl_q
    always_ff @(posedge clock) begin
        pkt_q <= pkt_d;
        id_q  <= id_d;
        if (gnt)
            mem_q[wr_q] <= {pkt_q[gnt_idx], id_q[gnt_idx], gnt_idx};
    end

    assign head       = mem_q[rd_q];
    assign out_valid  = (lvl_q != '0);
    assign out_packet = out_valid ? head[EW-1 -: DATA_SIZE] : '0;
    assign out_id     = out_valid ? head[NW +: ID_SIZE] : '0;
    assign out_node   = out_valid ? head[NW-1:0] : '0;
    assign fifo_level = lvl_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_rx_packet_collector.sv
// Directed self-checking bench for rx_packet_collector.
// Expected values are hand-derived from the edge-by-edge timeline.
module tb_rx_packet_collector;

    logic         clock;
    logic         reset;
    logic [3:0]   data_out_req;
    logic [255:0] rx_packet;
    logic [43:0]  rx_id;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_packet;
    logic [10:0]  out_id;
    logic [1:0]   out_node;
    logic [3:0]   fifo_level;
    logic [15:0]  drop_count;

    int vectors;
    int miscompares;
    int cnt;

    rx_packet_collector dut (
        .clock        (clock),
        .reset        (reset),
        .data_out_req (data_out_req),
        .rx_packet    (rx_packet),
        .rx_id        (rx_id),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_packet   (out_packet),
        .out_id       (out_id),
        .out_node     (out_node),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] pl(input int f);
        return 64'hA5A5_0000_0000_0000 | 64'(f);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int n, input logic [63:0] p,
                            input logic [10:0] d);
        rx_packet[n*64 +: 64] = p;
        rx_id[n*11 +: 11]     = d;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        data_out_req = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_level"}, 64'(fifo_level), 64'(0));
        chk({tag, "_drop"},  64'(drop_count), 64'(0));
        chk({tag, "_pkt"},   out_packet, 64'(0));
        chk({tag, "_id"},    64'(out_id), 64'(0));
        chk({tag, "_node"},  64'(out_node), 64'(0));
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        data_out_req = '0;
        rx_packet    = '0;
        rx_id        = '0;
        out_ready    = 1'b0;

        // Reset state
        tick();
        tick();
        chk_reset_vals("rst");
        reset = 1'b0;

        // Single frame on node 2, two-edge latency, one pop
        set_slot(2, 64'hDEAD_BEEF_0000_0001, 11'h123);
        out_ready    = 1'b1;
        data_out_req = 4'b0100;
        tick();
        data_out_req = '0;
        chk("t1_lat", 64'(out_valid), 64'(0));
        tick();
        chk("t1_valid", 64'(out_valid), 64'(1));
        chk("t1_pkt", out_packet, 64'hDEAD_BEEF_0000_0001);
        chk("t1_id", 64'(out_id), 64'h123);
        chk("t1_node", 64'(out_node), 64'(2));
        chk("t1_lvl", 64'(fifo_level), 64'(1));
        tick();
        chk("t1_empty", 64'(out_valid), 64'(0));
        chk("t1_lvl0", 64'(fifo_level), 64'(0));

        // Simultaneous rises from rr_ptr = 0
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) set_slot(n, pl(20 + n), 11'(12'h200 + n));
        data_out_req = 4'hF;
        tick();
        data_out_req = '0;
        tick();
        for (int n = 0; n < 4; n++) begin
            chk("t2_valid", 64'(out_valid), 64'(1));
            chk("t2_node", 64'(out_node), 64'(n));
            chk("t2_pkt", out_packet, pl(20 + n));
            tick();
        end
        chk("t2_empty", 64'(out_valid), 64'(0));
        chk("t2_drop", 64'(drop_count), 64'(0));

        // Node 1 grant leaves rr_ptr = 2, then all rise again
        set_slot(1, pl(30), 11'h030);
        data_out_req = 4'b0010;
        tick();
        data_out_req = '0;
        tick();
        chk("t2b_node1", 64'(out_node), 64'(1));
        tick();
        for (int n = 0; n < 4; n++) set_slot(n, pl(40 + n), 11'(12'h240 + n));
        data_out_req = 4'hF;
        tick();
        data_out_req = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t2b_node", 64'(out_node), 64'((2 + k) % 4));
            chk("t2b_pkt", out_packet, pl(40 + (2 + k) % 4));
            tick();
        end
        chk("t2b_empty", 64'(out_valid), 64'(0));
        chk("t2b_drop", 64'(drop_count), 64'(0));

        // Held request captures once
        cnt          = 0;
        data_out_req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid) cnt++;
        end
        data_out_req = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("t3_frames", 64'(cnt), 64'(1));

        // Fill FIFO with out_ready=0, then overwrite node 0
        do_reset();
        out_ready = 1'b0;
        for (int s = 0; s < 12; s++) begin
            set_slot(s % 4, pl(s), 11'(12'h100 + s));
            data_out_req = 4'(1 << (s % 4));
            tick();
        end
        data_out_req = '0;
        tick();
        tick();
        chk("t4_full", 64'(fifo_level), 64'(8));
        chk("t4_drop0", 64'(drop_count), 64'(0));
        chk("t4_head", out_packet, pl(0));
        set_slot(0, 64'h0000_0000_0000_0BAD, 11'h7FF);
        data_out_req = 4'b0001;
        tick();
        data_out_req = '0;
        tick();
        chk("t4_drop1", 64'(drop_count), 64'(1));
        chk("t4_full2", 64'(fifo_level), 64'(8));
        out_ready = 1'b1;
        for (int f = 0; f < 12; f++) begin
            chk("t4_valid", 64'(out_valid), 64'(1));
            chk("t4_node", 64'(out_node), 64'(f % 4));
            chk("t4_pkt", out_packet, pl(f));
            chk("t4_id", 64'(out_id), 64'(12'h100 + f));
            tick();
        end
        chk("t4_lvl0", 64'(fifo_level), 64'(0));
        chk("t4_drop", 64'(drop_count), 64'(1));

        // Full FIFO with pop and push in the same cycle
        do_reset();
        out_ready = 1'b0;
        for (int s = 0; s < 8; s++) begin
            set_slot(s % 4, pl(50 + s), 11'(12'h150 + s));
            data_out_req = 4'(1 << (s % 4));
            tick();
        end
        data_out_req = '0;
        tick();
        set_slot(3, pl(99), 11'h399);
        data_out_req = 4'b1000;
        tick();
        data_out_req = '0;
        tick();
        tick();
        chk("t5_full", 64'(fifo_level), 64'(8));
        chk("t5_head", out_packet, pl(50));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_lvl", 64'(fifo_level), 64'(8));
        chk("t5_head1", out_packet, pl(51));
        tick();
        chk("t5_hold", 64'(fifo_level), 64'(8));
        out_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            chk("t5_pkt", out_packet, pl(50 + k));
            tick();
        end
        chk("t5_n3node", 64'(out_node), 64'(3));
        chk("t5_n3pkt", out_packet, pl(99));
        chk("t5_n3id", 64'(out_id), 64'h399);
        tick();
        chk("t5_empty", 64'(out_valid), 64'(0));

        // Build level 5, two pending, drop 3; then reset mid-operation
        do_reset();
        out_ready = 1'b0;
        set_slot(3, pl(60), 11'h060);
        data_out_req = 4'b1000;
        tick();
        data_out_req = '0;
        tick();
        for (int n = 0; n < 4; n++) set_slot(n, pl(61 + n), 11'(12'h061 + n));
        data_out_req = 4'hF;
        tick();
        data_out_req = '0;
        tick();
        data_out_req = 4'hF;
        tick();
        data_out_req = '0;
        tick();
        data_out_req = 4'b0001;
        tick();
        data_out_req = '0;
        chk("t6_lvl5", 64'(fifo_level), 64'(5));
        chk("t6_drop3", 64'(drop_count), 64'(3));
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk_reset_vals("t6_rst");
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t6_stale", 64'(out_valid), 64'(0));
        end
        chk("t6_lvl", 64'(fifo_level), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
